// File: rtl/dif_radix2_64p_src.sv
// rtl/dif_radix2_64p_src.sv - ping-pong frame source feeding the 64-point DIF FFT
// Buffers an arbitrary-rate sample stream and replays each full frame as one gapless burst.
module dif_radix2_64p_src #(
  parameter int DATA_WIDTH = 10,
  parameter int FFT_LEN    = 64,
  parameter int GAP_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic [DATA_WIDTH-1:0] s_re,
  input  logic [DATA_WIDTH-1:0] s_im,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] din_re,
  output logic [DATA_WIDTH-1:0] din_im,
  output logic                  din_valid,
  output logic                  frame_start,
  output logic [1:0]            frames_ready
);
  localparam int AW = $clog2(FFT_LEN);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [AW-1:0] LAST = AW'(FFT_LEN - 1);

  typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

  logic [2*DATA_WIDTH-1:0] mem_q [2*FFT_LEN];

  logic [1:0]            full_q, full_d;
  logic                  wbank_q, wbank_d;
  logic [AW-1:0]         waddr_q, waddr_d;
  logic                  s_ready_q, s_ready_d;
  state_t                state_q;
  logic                  rbank_q;
  logic [AW-1:0]         raddr_q;
  logic [GW-1:0]         gap_cnt_q;
  logic [DATA_WIDTH-1:0] din_re_q, din_im_q;
  logic                  din_valid_q, frame_start_q;
  logic                  accept, release_bank;

  assign accept       = s_valid && s_ready_q && !clr;
  assign release_bank = (state_q == BURST) && (raddr_q == LAST) && !clr;

  // Release and write target different banks: a full read bank never equals an open write bank.
  always_comb begin
    full_d    = full_q;
    wbank_d   = wbank_q;
    waddr_d   = waddr_q;
    s_ready_d = 1'b1;
    if (clr) begin
      full_d  = '0;
      wbank_d = 1'b0;
      waddr_d = '0;
    end else begin
      if (release_bank) full_d[rbank_q] = 1'b0;
      if (accept) begin
        waddr_d = waddr_q + 1'b1;
        if (waddr_q == LAST) begin
          full_d[wbank_q] = 1'b1;
          wbank_d         = ~wbank_q;
        end
      end
      s_ready_d = !full_d[wbank_d];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q    <= '0;
      wbank_q   <= 1'b0;
      waddr_q   <= '0;
      s_ready_q <= 1'b0;
    end else begin
      full_q    <= full_d;
      wbank_q   <= wbank_d;
      waddr_q   <= waddr_d;
      s_ready_q <= s_ready_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem_q[{wbank_q, waddr_q}] <= {s_re, s_im};
  end

  // IDLE looks at next-state full so the first word follows the completing write by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rbank_q       <= 1'b0;
      raddr_q       <= '0;
      gap_cnt_q     <= '0;
      din_re_q      <= '0;
      din_im_q      <= '0;
      din_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (clr) begin
      state_q       <= IDLE;
      rbank_q       <= 1'b0;
      raddr_q       <= '0;
      gap_cnt_q     <= '0;
      din_re_q      <= '0;
      din_im_q      <= '0;
      din_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      din_re_q      <= '0;
      din_im_q      <= '0;
      din_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (full_d[rbank_q]) begin
            state_q <= BURST;
            raddr_q <= '0;
          end
        end
        BURST: begin
          {din_re_q, din_im_q} <= mem_q[{rbank_q, raddr_q}];
          din_valid_q          <= 1'b1;
          frame_start_q        <= (raddr_q == '0);
          raddr_q              <= raddr_q + 1'b1;
          if (raddr_q == LAST) begin
            rbank_q   <= ~rbank_q;
            gap_cnt_q <= '0;
            state_q   <= (GAP_CYCLES > 0) ? GAP : IDLE;
          end
        end
        GAP: begin
          if (int'(gap_cnt_q) >= GAP_CYCLES - 1) state_q <= IDLE;
          else gap_cnt_q <= gap_cnt_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_ready      = s_ready_q;
  assign din_re       = din_re_q;
  assign din_im       = din_im_q;
  assign din_valid    = din_valid_q;
  assign frame_start  = frame_start_q;
  assign frames_ready = {1'b0, full_q[0]} + {1'b0, full_q[1]};
endmodule

// File: tb/tb_dif_radix2_64p_src.sv
// tb/tb_dif_radix2_64p_src.sv - self-checking bench for the ping-pong FFT frame source
module tb_dif_radix2_64p_src;
  localparam int DW  = 10;
  localparam int N   = 64;
  localparam int GAP = 8;

  logic          clk = 1'b0;
  logic          rst_n, clr, s_valid, s_ready, din_valid, frame_start;
  logic [DW-1:0] s_re, s_im, din_re, din_im;
  logic [1:0]    frames_ready;

  int nchk = 0, nfail = 0, cyc = 0;
  int nfull = 0, out_pos = 0, run = 0, low = 0, sready_low = 0;
  bit cut = 0, gap_chk = 0, sr_chk = 0, last_acc = 0, bp_phase = 0;
  logic [2*DW-1:0] pend[$];
  logic [2*DW-1:0] expq[$];
  int done_cyc[$];

  dif_radix2_64p_src #(.DATA_WIDTH(DW), .FFT_LEN(N), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .s_re(s_re), .s_im(s_im), .s_valid(s_valid), .s_ready(s_ready),
    .din_re(din_re), .din_im(din_im), .din_valid(din_valid),
    .frame_start(frame_start), .frames_ready(frames_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    nchk++;
    assert (obs === exp_v) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Reference: frames leave in arrival order, 64 words per contiguous burst; full banks = frames not yet replayed.
  task automatic check_outputs();
    logic [2*DW-1:0] w;
    if (din_valid === 1'b1) begin
      if (low > 0 && gap_chk) chk("gap_len", 32'(low), GAP + 1);
      low = 0;
      chk("frame_start", 32'(frame_start), 32'(out_pos == 0));
      if (expq.size() == 0) chk("spurious_valid", 32'(din_valid), 0);
      else begin
        w = expq.pop_front();
        chk("din_re", 32'(din_re), 32'(w[2*DW-1:DW]));
        chk("din_im", 32'(din_im), 32'(w[DW-1:0]));
      end
      out_pos++;
      run++;
      if (out_pos == N) begin
        out_pos = 0;
        nfull--;
      end
    end else begin
      chk("idle_re", 32'(din_re), 0);
      chk("idle_im", 32'(din_im), 0);
      chk("idle_fs", 32'(frame_start), 0);
      if (run > 0 && !cut) chk("burst_len", 32'(run), N);
      if (run > 0 && bp_phase) gap_chk = 1;
      run = 0;
      cut = 0;
      low++;
    end
    chk("frames_ready", 32'(frames_ready), nfull);
    if (sr_chk) chk("s_ready", 32'(s_ready), 32'(nfull < 2));
    if (s_ready === 1'b0) sready_low++;
  endtask

  task automatic tick();
    bit acc;
    acc = (s_valid === 1'b1) && (s_ready === 1'b1) && (clr === 1'b0);
    @(posedge clk);
    cyc++;
    last_acc = 0;
    if (clr === 1'b1) begin
      pend.delete();
      expq.delete();
      nfull   = 0;
      out_pos = 0;
      cut     = 1;
    end else if (acc) begin
      last_acc = 1;
      pend.push_back({s_re, s_im});
      if (pend.size() == N) begin
        foreach (pend[i]) expq.push_back(pend[i]);
        pend.delete();
        nfull++;
        done_cyc.push_back(cyc);
      end
    end
    if (rst_n === 1'b1) sr_chk = 1;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic send(input logic [DW-1:0] re, input logic [DW-1:0] im);
    int n = 0;
    s_re    = re;
    s_im    = im;
    s_valid = 1'b1;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 200);
    chk("send_accept", 32'(last_acc), 1);
  endtask

  task automatic drain(input int limit);
    int n = 0;
    s_valid = 1'b0;
    while ((expq.size() > 0 || din_valid === 1'b1) && n < limit) begin
      tick();
      n++;
    end
    chk("drain", 32'(expq.size()), 0);
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; s_valid = 1'b0; s_re = '0; s_im = '0;
    repeat (3) @(negedge clk);
    chk("rst_sready", 32'(s_ready), 0);
    chk("rst_valid", 32'(din_valid), 0);
    chk("rst_re", 32'(din_re), 0);
    chk("rst_im", 32'(din_im), 0);
    chk("rst_fs", 32'(frame_start), 0);
    chk("rst_fr", 32'(frames_ready), 0);
    rst_n = 1'b1;
    chk("sready_pre_edge", 32'(s_ready), 0);
    tick();
    chk("sready_post_reset", 32'(s_ready), 1);

    // Ramp at full rate
    for (int n = 0; n < N; n++) send(DW'(n), DW'(-n));
    s_valid = 1'b0;
    chk("ramp_lat_lo", 32'(din_valid), 0);
    chk("ramp_fr", 32'(frames_ready), 1);
    tick();
    chk("ramp_lat_hi", 32'(din_valid), 1);
    chk("ramp_fs", 32'(frame_start), 1);
    chk("ramp_first", 32'(din_re), 0);
    drain(200);

    // Sparse input, one sample every third cycle
    for (int n = 0; n < N; n++) begin
      send(DW'($urandom), DW'($urandom));
      s_valid = 1'b0;
      if (n < N - 1) begin
        tick();
        tick();
      end
    end
    chk("sparse_lat_lo", 32'(din_valid), 0);
    tick();
    chk("sparse_lat_hi", 32'(din_valid), 1);
    drain(200);

    // Backpressure with s_valid held high for ten frames
    bp_phase = 1; gap_chk = 0; sready_low = 0; done_cyc.delete();
    for (int n = 0; n < 10 * N; n++) send(DW'($urandom), DW'($urandom));
    drain(400);
    bp_phase = 0; gap_chk = 0;
    chk("bp_frames", 32'(done_cyc.size()), 10);
    chk("bp_sready_low", 32'(sready_low > 0), 1);
    if (done_cyc.size() == 10)
      for (int k = 3; k < 10; k++) chk("bp_period", 32'(done_cyc[k] - done_cyc[k-1]), N + GAP + 1);

    // Soft clear mid-frame
    for (int n = 0; n < 40; n++) send(DW'($urandom), DW'($urandom));
    s_valid = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_fr", 32'(frames_ready), 0);
    chk("clr_sready", 32'(s_ready), 1);
    for (int n = 0; n < N; n++) send(DW'(100 + n), DW'($urandom));
    s_valid = 1'b0;
    tick();
    chk("clr_first", 32'(din_re), 100);
    drain(200);

    // Clear at burst word 20 while the next frame is still arriving
    for (int n = 0; n < N; n++) send(DW'($urandom), DW'($urandom));
    for (int n = 0; n < 21; n++) send(DW'($urandom), DW'($urandom));
    chk("cb_in_burst", 32'(din_valid), 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    s_valid = 1'b0;
    chk("cb_drop", 32'(din_valid), 0);
    chk("cb_fr", 32'(frames_ready), 0);
    repeat (100) tick();
    chk("cb_quiet", 32'(din_valid), 0);

    // Asynchronous reset mid-burst
    for (int n = 0; n < N; n++) send(DW'($urandom), DW'($urandom));
    s_valid = 1'b0;
    repeat (11) tick();
    chk("rb_in_burst", 32'(din_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rb_valid", 32'(din_valid), 0);
    chk("rb_re", 32'(din_re), 0);
    chk("rb_im", 32'(din_im), 0);
    chk("rb_fs", 32'(frame_start), 0);
    chk("rb_fr", 32'(frames_ready), 0);
    chk("rb_sready", 32'(s_ready), 0);
    pend.delete(); expq.delete();
    nfull = 0; out_pos = 0; run = 0; low = 0; cut = 0; sr_chk = 0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rb_sready_pre", 32'(s_ready), 0);
    tick();
    chk("rb_sready_post", 32'(s_ready), 1);
    for (int n = 0; n < N; n++) send(DW'($urandom), DW'($urandom));
    drain(200);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/dif_radix2_64p_src.md
# dif_radix2_64p_src

Streaming frame source that sits in front of the 64-point DIF radix-2 FFT and drives its `din_re`/`din_im`/`din_valid` input. It accepts samples from an upstream valid/ready stream at any rate and stores them in a two-bank ping-pong buffer. Each complete 64-sample frame is emitted as one uninterrupted 64-cycle `din_valid` burst, which is the only input pattern the FFT control sequencer accepts. A programmable idle gap between bursts is available.

## Interface
- `DATA_WIDTH`, 10, sample width per component; matches the FFT `DATA_WIDTH_IN`.
- `FFT_LEN`, 64, samples per frame; must be a power of two.
- `GAP_CYCLES`, 0, minimum idle cycles with `din_valid` low between consecutive bursts.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `clr`  in  1  synchronous soft clear.
- `s_re`  in  DATA_WIDTH  upstream sample, real part.
- `s_im`  in  DATA_WIDTH  upstream sample, imaginary part.
- `s_valid`  in  1  upstream sample valid.
- `s_ready`  out  1  source can accept a sample (registered).
- `din_re`  out  DATA_WIDTH  sample to the FFT, real part.
- `din_im`  out  DATA_WIDTH  sample to the FFT, imaginary part.
- `din_valid`  out  1  FFT input valid.
- `frame_start`  out  1  one-cycle pulse coincident with the first `din_valid` of each burst.
- `frames_ready`  out  2  number of full banks not yet fully emitted (0..2).

## Operation
- Storage: two banks of `FFT_LEN` complex words. Each bank has a `full` flag.
- Write side: bank pointer `wbank` and address `waddr`.
  - A sample is accepted on an edge where `s_valid && s_ready`. It is stored at `bank[wbank][waddr]` and `waddr` increments.
  - Acceptance at `waddr == FFT_LEN-1` sets `full[wbank]`, toggles `wbank` and wraps `waddr` to 0.
- `s_ready` is registered. Its next value is `!full_next[wbank_next]`, so it never accepts into a full bank.
- Read FSM states: IDLE, BURST, GAP.
  - **IDLE**: if `full[rbank]`, go to BURST with `raddr = 0`.
  - **BURST**: each cycle, register `bank[rbank][raddr]` onto `din_re`/`din_im` with `din_valid = 1`, then increment `raddr`. On the word at `raddr == FFT_LEN-1`:
    - clear `full[rbank]` and toggle `rbank`;
    - go to GAP if `GAP_CYCLES > 0`, otherwise go to IDLE.
  - **GAP**: count `GAP_CYCLES` cycles, then go to IDLE.
- When `din_valid = 0`, `din_re` and `din_im` are driven to 0.
- A burst is never interrupted by the write side. Only `clr` or `rst_n` can end it early.
- Simultaneous release and write:
  - The release of `full[rbank]` and a write into the other bank on the same edge are both honoured.
  - A freed bank becomes writable one cycle later (through the `s_ready` register).
- `frames_ready` equals `full[0] + full[1]`.
- `clr`:
  - On the next edge, clears both `full` flags and all pointers, which drops any partial frame.
  - Forces the FSM to IDLE: `din_valid` goes low on that edge, even mid-burst.
  - Sets `s_ready` to 1.
  - If a burst was cut short, the downstream FFT must be reset by the user.
- `rst_n` low: asynchronously clears all flops, including the `s_ready` register and FSM state.

## Timing
- Reset values: `s_ready = 0`, `din_re = din_im = 0`, `din_valid = 0`, `frame_start = 0`, `frames_ready = 0`, FSM in IDLE.
- `s_ready` rises on the first `clk` edge after `rst_n` deasserts.
- Latency: if the last sample of a frame is accepted on edge E, then `full` is visible after E, and `din_valid` plus `frame_start` assert after edge E+1. That is one idle cycle between the last accept and the first output word.
- Burst length is exactly `FFT_LEN` consecutive cycles.
- With `GAP_CYCLES = 0` and the other bank already full, the next burst starts two cycles after the previous burst's last word (one IDLE cycle).
- Steady-state throughput is bounded by `FFT_LEN` samples per `FFT_LEN + GAP_CYCLES + 1` cycles.
- The output never stalls; backpressure appears only on `s_ready`.

## Test plan
- **Reset and ramp**: after reset, send 64 samples, re = n and im = -n, at full rate.
  - `s_ready` is 1 one cycle after reset release.
  - `din_valid` is high for 64 consecutive cycles, starting two edges after the 64th accept.
  - `din_re` runs 0..63; `frame_start` pulses once; `frames_ready` goes 1 -> 0.
- **Sparse input**: send 64 samples with `s_valid` high every third cycle.
  - Output is still one contiguous 64-cycle burst with no gaps.
  - The burst starts two edges after the final accept.
- **Backpressure**: `GAP_CYCLES = 8`, with `s_valid` held high for 10 frames.
  - `s_ready` deasserts periodically.
  - Steady-state accept rate is 64 samples per 73 cycles.
  - Output data is in order and equal to the input; bursts are separated by exactly 9 low cycles.
- **Soft clear mid-frame**: pulse `clr` after 40 samples, then send values 100..163.
  - One burst is emitted carrying 100..163.
  - The first 40 samples never appear at the output.
- **Clear and reset during a burst**:
  - `clr` at burst word 20: `din_valid` drops on the next edge, `frames_ready = 0`, and the pending second frame is discarded.
  - Repeat with asynchronous `rst_n` low mid-burst: all outputs go to 0 immediately, without waiting for a clock edge.
